// File: rtl/driver_bus_rtc.sv
// driver_bus_rtc
// Turns one request from the RTC time-write controller into a multiplexed
// address/data bus transaction for a V3023-style RTC. Each transaction is an
// address phase (always strobed with wr_n) followed by a data phase (wr_n for
// a write, rd_n for a read), separated by a chip-select gap.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   flag_rtc         request; a 0->1 edge seen in IDLE starts a transaction
//   lea_escriba      1 = write, 0 = read (latched at start)
//   direc, dato_smh  register address and write data (latched at start)
//   siga             active-low one-cycle done pulse, 1 when idle
//   tome             one-cycle strobe: rtc holds freshly read data
//   rtc              last byte read from the RTC
//   busy             high from start through the done cycle
//   cs_n, rd_n, wr_n RTC chip select / read / write strobes, active low
//   ad_n             0 = address phase, 1 = data phase
//   ad               bidirectional multiplexed address/data bus
module driver_bus_rtc #(
  parameter int unsigned CYC_SETUP = 1,
  parameter int unsigned CYC_PULSE = 4,
  parameter int unsigned CYC_HOLD  = 1,
  parameter int unsigned CYC_GAP   = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flag_rtc,
  input  logic       lea_escriba,
  input  logic [7:0] direc,
  input  logic [7:0] dato_smh,
  output logic       siga,
  output logic       tome,
  output logic [7:0] rtc,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  inout  wire  [7:0] ad
);

  // A zero-length phase would break the bus timing, so every phase lasts at
  // least one cycle.
  localparam int unsigned SETUP_E = (CYC_SETUP < 1) ? 1 : CYC_SETUP;
  localparam int unsigned PULSE_E = (CYC_PULSE < 1) ? 1 : CYC_PULSE;
  localparam int unsigned HOLD_E  = (CYC_HOLD  < 1) ? 1 : CYC_HOLD;
  localparam int unsigned GAP_E   = (CYC_GAP   < 1) ? 1 : CYC_GAP;

  // Counter reload values: a phase ends on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_E - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_E - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_E - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_E - 1);

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    GAP,
    D_SETUP,
    D_STROBE,
    D_HOLD,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             flag_prev_reg;
  logic [7:0]       addr_reg, data_reg;
  logic             we_reg;

  logic             cs_n_reg, cs_n_next;
  logic             rd_n_reg, rd_n_next;
  logic             wr_n_reg, wr_n_next;
  logic             ad_n_reg, ad_n_next;
  logic             ad_oe_reg, ad_oe_next;
  logic [7:0]       ad_out_reg, ad_out_next;
  logic             siga_reg, siga_next;
  logic             tome_reg, tome_next;
  logic             busy_reg, busy_next;
  logic [7:0]       rtc_reg;

  logic             start;
  logic             last;
  logic             capture;
  logic [7:0]       addr_eff, data_eff;
  logic             we_eff;

  assign start   = (state_reg == IDLE) && flag_rtc && !flag_prev_reg;
  assign last    = (cnt_reg == '0);
  // Read data is taken on the final strobe cycle, while rd_n is still low.
  assign capture = (state_reg == D_STROBE) && last && !we_reg;

  // The request fields are latched on the start edge, but the first bus
  // cycle is decoded in that same clock, so bypass the latches on start.
  assign addr_eff = start ? direc       : addr_reg;
  assign data_eff = start ? dato_smh    : data_reg;
  assign we_eff   = start ? lea_escriba : we_reg;

  // Next-state and phase counter.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = A_SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      A_SETUP: begin
        if (last) begin
          state_next = A_STROBE;
          cnt_next   = PULSE_LD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      A_STROBE: begin
        if (last) begin
          state_next = A_HOLD;
          cnt_next   = HOLD_LD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      A_HOLD: begin
        if (last) begin
          state_next = GAP;
          cnt_next   = GAP_LD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      GAP: begin
        if (last) begin
          state_next = D_SETUP;
          cnt_next   = SETUP_LD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      D_SETUP: begin
        if (last) begin
          state_next = D_STROBE;
          cnt_next   = PULSE_LD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      D_STROBE: begin
        if (last) begin
          state_next = D_HOLD;
          cnt_next   = HOLD_LD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      D_HOLD: begin
        if (last) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the next state, so every bus pin comes from a flop
  // and changes on the same edge as the state it belongs to.
  always_comb begin
    cs_n_next   = 1'b1;
    rd_n_next   = 1'b1;
    wr_n_next   = 1'b1;
    ad_n_next   = 1'b1;
    ad_oe_next  = 1'b0;
    ad_out_next = addr_eff;
    siga_next   = 1'b1;
    tome_next   = 1'b0;
    busy_next   = (state_next != IDLE);
    case (state_next)
      A_SETUP, A_HOLD: begin
        cs_n_next  = 1'b0;
        ad_n_next  = 1'b0;
        ad_oe_next = 1'b1;
      end
      A_STROBE: begin
        cs_n_next  = 1'b0;
        ad_n_next  = 1'b0;
        ad_oe_next = 1'b1;
        wr_n_next  = 1'b0;
      end
      D_SETUP, D_HOLD: begin
        cs_n_next   = 1'b0;
        ad_oe_next  = we_eff;
        ad_out_next = data_eff;
      end
      D_STROBE: begin
        cs_n_next   = 1'b0;
        ad_oe_next  = we_eff;
        ad_out_next = data_eff;
        wr_n_next   = !we_eff;
        rd_n_next   = we_eff;
      end
      DONE: begin
        siga_next = 1'b0;
        tome_next = !we_eff;
      end
      default: begin
        cs_n_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // The request level is tracked through reset too, so a level already
    // high when reset releases is not taken as a fresh edge.
    flag_prev_reg <= flag_rtc;
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      we_reg     <= 1'b0;
      cs_n_reg   <= 1'b1;
      rd_n_reg   <= 1'b1;
      wr_n_reg   <= 1'b1;
      ad_n_reg   <= 1'b1;
      ad_oe_reg  <= 1'b0;
      ad_out_reg <= '0;
      siga_reg   <= 1'b1;
      tome_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      rtc_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      if (start) begin
        addr_reg <= direc;
        data_reg <= dato_smh;
        we_reg   <= lea_escriba;
      end
      cs_n_reg   <= cs_n_next;
      rd_n_reg   <= rd_n_next;
      wr_n_reg   <= wr_n_next;
      ad_n_reg   <= ad_n_next;
      ad_oe_reg  <= ad_oe_next;
      ad_out_reg <= ad_out_next;
      siga_reg   <= siga_next;
      tome_reg   <= tome_next;
      busy_reg   <= busy_next;
      if (capture) begin
        rtc_reg <= ad;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ad_drv
      assign ad[gi] = ad_oe_reg ? ad_out_reg[gi] : 1'bz;
    end
  endgenerate

  assign cs_n = cs_n_reg;
  assign rd_n = rd_n_reg;
  assign wr_n = wr_n_reg;
  assign ad_n = ad_n_reg;
  assign siga = siga_reg;
  assign tome = tome_reg;
  assign busy = busy_reg;
  assign rtc  = rtc_reg;

endmodule

// File: tb/tb_driver_bus_rtc.sv
// Testbench for driver_bus_rtc: directed transactions push their expected
// outcome into a queue; a negedge monitor traces each bus transaction and
// compares it against the queue head when siga pulses.
module tb_driver_bus_rtc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flag_rtc = 1'b0;
  logic       lea_escriba = 1'b0;
  logic [7:0] direc = 8'h00;
  logic [7:0] dato_smh = 8'h00;
  logic       siga, tome, busy, cs_n, rd_n, wr_n, ad_n;
  logic [7:0] rtc;
  wire  [7:0] ad;

  // Second instance with short timing
  logic       flag2 = 1'b0;
  logic       siga2, tome2, busy2, cs_n2, rd_n2, wr_n2, ad_n2;
  logic [7:0] rtc2;
  wire  [7:0] ad2;

  logic [7:0] rtc_drv = 8'h5A;

  always #5 clk = ~clk;

  // RTC model: drives the bus only while it is being read.
  assign ad = (rd_n == 1'b0) ? rtc_drv : 8'hzz;

  driver_bus_rtc u_dut (
    .clk(clk), .reset(reset), .flag_rtc(flag_rtc), .lea_escriba(lea_escriba),
    .direc(direc), .dato_smh(dato_smh), .siga(siga), .tome(tome), .rtc(rtc),
    .busy(busy), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n), .ad(ad)
  );

  driver_bus_rtc #(.CYC_SETUP(0), .CYC_PULSE(1), .CYC_HOLD(1), .CYC_GAP(1)) u_dut2 (
    .clk(clk), .reset(reset), .flag_rtc(flag2), .lea_escriba(1'b1),
    .direc(8'h12), .dato_smh(8'h34), .siga(siga2), .tome(tome2), .rtc(rtc2),
    .busy(busy2), .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2), .ad_n(ad_n2), .ad(ad2)
  );

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rtc;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   errors = 0;
  int   viol = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor state
  bit   in_txn = 0;
  bit   have_exp = 0;
  exp_t cur;
  int   t, a_cyc, a_wr, a_wr_first, gap, d_wr, rd_lo;

  always @(negedge clk) begin
    if (!rd_n && !wr_n) viol++;
    if (u_dut.ad_oe_reg && !rd_n) viol++;
    if (u_dut.ad_oe_reg && cs_n) viol++;
    if (!in_txn) begin
      if (busy) begin
        in_txn = 1; t = 0; a_cyc = 0; a_wr = 0; a_wr_first = -1;
        gap = 0; d_wr = 0; rd_lo = 0;
        have_exp = (q.size() > 0);
        if (have_exp) cur = q[0];
        else cur = '{we: 1'b1, addr: 8'h00, data: 8'h00, rtc: 8'h00};
      end else if (!siga || tome) begin
        compared++; errors++;
        $display("FAIL idle_pulse actual siga=%0b tome=%0b required siga=1 tome=0", siga, tome);
      end
    end
    if (in_txn) begin
      if (!ad_n && !cs_n && u_dut.ad_oe_reg && ad == cur.addr) a_cyc++;
      if (!ad_n && !wr_n) begin
        a_wr++;
        if (a_wr_first < 0) a_wr_first = t;
      end
      if (cs_n && siga) gap++;
      if (ad_n && !cs_n && !wr_n) begin
        d_wr++;
        if (have_exp && !(u_dut.ad_oe_reg && ad == cur.data)) viol++;
      end
      if (!rd_n) rd_lo++;
      if (!cur.we && ad_n && u_dut.ad_oe_reg) viol++;
      if (siga && tome) viol++;
      if (!siga) begin
        if (!have_exp) begin
          compared++; errors++;
          $display("FAIL unexpected_txn actual=siga pulse required=none");
        end else begin
          void'(q.pop_front());
          $display("txn %0d %s addr=%02h: lat=%0d acyc=%0d awr=%0d gap=%0d dwr=%0d rdlo=%0d tome=%0b rtc=%02h",
                   done_cnt, cur.we ? "WR" : "RD", cur.addr, t, a_cyc, a_wr, gap, d_wr, rd_lo, tome, rtc);
          chk("latency", t, 14);
          chk("addr_cycles", a_cyc, 6);
          chk("addr_wr_low", a_wr, 4);
          chk("addr_wr_first", a_wr_first, 1);
          chk("gap_cycles", gap, 2);
          chk("data_wr_low", d_wr, cur.we ? 4 : 0);
          chk("rd_low", rd_lo, cur.we ? 0 : 4);
          chk("tome_at_done", {31'b0, tome}, {31'b0, !cur.we});
          chk("rtc_at_done", {24'b0, rtc}, {24'b0, cur.rtc});
        end
        done_cnt++;
        in_txn = 0;
      end else if (!busy) begin
        in_txn = 0;
      end else if (t >= 60) begin
        compared++; errors++;
        $display("FAIL txn_timeout actual=%0d cycles required<=14", t);
        in_txn = 0;
      end
      t++;
    end
  end

  task automatic start_txn(input bit we, input logic [7:0] a, input logic [7:0] d,
                           input bit push, input logic [7:0] exp_rtc);
    @(negedge clk);
    flag_rtc = 1'b0;
    @(negedge clk);
    lea_escriba = we; direc = a; dato_smh = d; flag_rtc = 1'b1;
    if (push) q.push_back('{we: we, addr: a, data: d, rtc: exp_rtc});
    @(negedge clk);
    // Scramble the request fields: they must already be latched.
    lea_escriba = !we; direc = ~a; dato_smh = ~d; flag_rtc = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (done_cnt < target && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(name, done_cnt, target);
  endtask

  initial begin
    int k, lat;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", cs_n, 1); chk("rst_rd_n", rd_n, 1); chk("rst_wr_n", wr_n, 1);
    chk("rst_ad_n", ad_n, 1); chk("rst_ad_oe", u_dut.ad_oe_reg, 0);
    chk("rst_siga", siga, 1); chk("rst_tome", tome, 0);
    chk("rst_rtc", rtc, 8'h00); chk("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;

    // Write, read, then a write that must leave rtc alone
    start_txn(1'b1, 8'h21, 8'h45, 1'b1, 8'h00);
    wait_done(1, "done_write1");
    start_txn(1'b0, 8'hF1, 8'h33, 1'b1, 8'h5A);
    wait_done(2, "done_read");
    start_txn(1'b1, 8'h0A, 8'h77, 1'b1, 8'h5A);
    wait_done(3, "done_write2");

    // Extra edges while busy are dropped; a held level does not retrigger
    start_txn(1'b1, 8'h30, 8'hC3, 1'b1, 8'h5A);
    @(negedge clk) flag_rtc = 1'b1;
    @(negedge clk) flag_rtc = 1'b0;
    @(negedge clk) flag_rtc = 1'b1;
    wait_done(4, "done_extra");
    repeat (30) @(negedge clk);
    chk("extra_single_txn", done_cnt, 4);
    chk("extra_idle_busy", busy, 0);
    flag_rtc = 1'b0;

    // Reset in the middle of the write data strobe
    start_txn(1'b1, 8'h40, 8'h99, 1'b0, 8'h00);
    k = 0;
    while (!(ad_n && !wr_n) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reach_dstrobe", {31'b0, ad_n && !wr_n}, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_cs_n", cs_n, 1); chk("mid_rd_n", rd_n, 1); chk("mid_wr_n", wr_n, 1);
    chk("mid_ad_oe", u_dut.ad_oe_reg, 0); chk("mid_busy", busy, 0);
    chk("mid_siga", siga, 1); chk("mid_rtc", rtc, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_no_done", done_cnt, 4);

    // Short-timing instance: setup of 0 behaves as 1
    @(negedge clk) flag2 = 1'b1;
    lat = -1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (!siga2) begin
        lat = j;
        break;
      end
    end
    $display("txn p6 WR addr=12: lat=%0d tome=%0b", lat, tome2);
    chk("p6_latency", lat, 7);
    chk("p6_tome", tome2, 0);
    @(negedge clk);
    chk("p6_idle_busy", busy2, 0);
    chk("p6_idle_siga", siga2, 1);

    chk("queue_empty", q.size(), 0);
    chk("invariants", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/driver_bus_rtc.md
Name: driver_bus_rtc

Overview:
Downstream neighbour of the RTC time-write controller. Converts its transaction requests (flag_rtc, lea_escriba, direc, dato_smh) into timed, multiplexed address/data bus cycles for the external RTC (V3023-style: CS#, RD#, WR#, A/D#, bidirectional AD[7:0]). Returns siga (active-low, one-cycle "transaction done") and tome/rtc (one-cycle read-data strobe and captured byte). One transaction equals one address phase followed by one data phase.

Parameters:
CYC_SETUP, 1, cycles AD/A-D# are stable before the strobe falls (min 1; 0 treated as 1)
CYC_PULSE, 4, cycles the WR# or RD# strobe is held low (min 1)
CYC_HOLD, 1, cycles AD/CS# are held after the strobe rises (min 1)
CYC_GAP, 2, cycles with CS# high between the address and data phases (min 1)
CNT_W, 8, width of the phase counter; every CYC_* value must be < 2^CNT_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
flag_rtc  in  1  transaction request; start on 0->1 edge
lea_escriba  in  1  1 = write, 0 = read; sampled at start
direc  in  8  register address; sampled at start
dato_smh  in  8  write data; sampled at start
siga  out  1  active-low done pulse; 1 when idle
tome  out  1  high one cycle when rtc holds fresh read data
rtc  out  8  last byte read from the RTC
busy  out  1  high from start until the siga pulse, inclusive
cs_n  out  1  RTC chip select, active low
rd_n  out  1  RTC read strobe, active low
wr_n  out  1  RTC write strobe, active low
ad_n  out  1  RTC A/D# select: 0 = address phase, 1 = data phase
ad  inout  8  multiplexed address/data bus

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All outputs are registered.
- Reset values: cs_n=1, rd_n=1, wr_n=1, ad_n=1, ad=Z (driver off), siga=1, tome=0, rtc=8'h00, busy=0, state=IDLE, counter=0.
- Start detection: flag_rtc is registered. A start occurs at an edge where flag_rtc=1 and the previous sample was 0, and only in IDLE. Edges arriving while busy are ignored, not queued. A level held high does not retrigger.
- On start: latch direc, dato_smh and lea_escriba into internal registers. Later changes to those inputs have no effect until the next start.
- FSM states; each timed state lasts exactly its CYC_* count, measured by a down-counter reloaded on entry:
  - IDLE: all strobes high; ad=Z; busy=0. Go to A_SETUP on start.
  - A_SETUP: cs_n=0, ad_n=0, ad=latched address. Lasts CYC_SETUP.
  - A_STROBE: wr_n=0, address still driven. Lasts CYC_PULSE. The address phase always uses WR#.
  - A_HOLD: wr_n=1, cs_n=0, address still driven. Lasts CYC_HOLD.
  - GAP: cs_n=1, ad=Z, ad_n=1. Lasts CYC_GAP.
  - D_SETUP: cs_n=0, ad_n=1. For a write, ad=latched data; for a read, ad=Z. Lasts CYC_SETUP.
  - D_STROBE: wr_n=0 for a write, rd_n=0 for a read. Lasts CYC_PULSE. For a read, ad is sampled into rtc on the last cycle of D_STROBE, while rd_n is still 0.
  - D_HOLD: strobes high, cs_n=0; write data is still driven. Lasts CYC_HOLD.
  - DONE: cs_n=1, ad=Z, siga=0 for exactly 1 cycle, tome=1 for that same cycle if the transaction was a read. Next state is IDLE.
- Latency: from the start edge to the DONE cycle is 2*(CYC_SETUP+CYC_PULSE+CYC_HOLD)+CYC_GAP clocks. With defaults this is 14.
- Invariants:
  - rd_n and wr_n are never 0 simultaneously.
  - ad is never driven while rd_n=0.
  - ad is driven only while cs_n=0.
- Reset mid-transaction: at the next clk edge with reset=1, all strobes go inactive, ad=Z, and state=IDLE. No siga or tome pulse is produced. rtc is cleared to 8'h00.
- Start in the same cycle that DONE is exiting: ignored, because the state is not yet IDLE. The requester must re-issue a rising edge.
- rtc holds its value between reads. Write transactions do not modify rtc.

Test Plan:
1. Reset with flag_rtc=0 -> cs_n=rd_n=wr_n=ad_n=1, ad=Z, siga=1, tome=0, rtc=00, busy=0.
2. Write with defaults: direc=21, dato_smh=45, lea_escriba=1, flag_rtc 0->1 -> the following must hold:
   - ad=21 with ad_n=0 for 6 cycles, with wr_n low for cycles 2-5;
   - cs_n high for 2 cycles;
   - ad=45 with ad_n=1 and wr_n low for 4 cycles;
   - siga=0 exactly 14 cycles after the start edge; tome stays 0; rtc unchanged.
3. Read: direc=F1, lea_escriba=0, bench models the RTC driving 5A while rd_n=0 -> rd_n low for 4 cycles, wr_n stays 1 in the data phase, FPGA leaves ad undriven in the data phase, rtc=5A, and tome=1 together with siga=0 for one cycle.
4. Extra request: flag_rtc toggles 0->1->0->1 during a busy write -> only one transaction occurs, then return to IDLE; holding flag_rtc=1 afterwards starts nothing.
5. Reset asserted during D_STROBE of a write -> all strobes 1 and ad=Z on the next edge, no siga pulse, busy=0.
6. Parameters CYC_SETUP=0, CYC_PULSE=1, CYC_HOLD=1, CYC_GAP=1 -> setup is treated as 1 and siga goes low 7 cycles after the start edge.
